sound_cmd_fifo: RTL and testbench

//   Parametrised 68K<->Z80 sound-command mailbox, successor to the single-byte REG_SOUND latch.
//   68K writes to REG_SOUND push into a command FIFO that the Z80 drains through its command port.
//   Z80 replies push into a reply FIFO that the 68K drains by reading REG_SOUND.

---
 rtl/sound_cmd_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_sound_cmd_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_cmd_fifo.sv
// 68K<->Z80 sound-command mailbox: command FIFO (68K -> Z80) and reply FIFO (Z80 -> 68K).
// Optional build macro SOUND_CMD_OVF_EN adds a sticky dropped-command flag (CMD_OVF / CMD_OVF_CLR).

// First-word-fall-through FIFO; DEPTH must be a power of two, DEPTH=1 degenerates to a latch + flag.
module sound_cmd_fifo_q #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nSDZ80CLR,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              valid,
    output logic              drop
);

    logic full_q;
    logic valid_q;
    logic do_push;
    logic do_pop;

    // Pop only when something is queued; push is accepted when not full or when a pop frees a slot.
    assign do_pop  = pop & valid_q;
    assign do_push = push & (~full_q | do_pop);
    assign drop    = push & ~do_push;
    assign full    = full_q;
    assign valid   = valid_q;

    if (DEPTH > 1) begin : g_multi
        localparam int unsigned PTR_W = $clog2(DEPTH);

        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count_q;
        logic [CNT_W-1:0]  count_next;

        always_comb begin
            count_next = count_q;
            if (do_push && !do_pop) begin
                count_next = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_next = count_q - CNT_W'(1);
            end
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge CLK or negedge nSDZ80CLR) begin
            if (!nSDZ80CLR) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem[i] <= '0;
                end
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                full_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count_q <= count_next;
                full_q  <= (count_next == CNT_W'(DEPTH));
                valid_q <= (count_next != '0);
            end
        end

        assign head  = valid_q ? mem[rd_ptr] : '0;
        assign count = count_q;
    end else begin : g_single
        logic [DATA_W-1:0] data_q;

        always_ff @(posedge CLK or negedge nSDZ80CLR) begin
            if (!nSDZ80CLR) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                if (do_push) begin
                    data_q <= din;
                end
                valid_q <= do_push | (valid_q & ~do_pop);
            end
        end

        assign full_q = valid_q;
        assign head   = valid_q ? data_q : '0;
        assign count  = CNT_W'(valid_q);
    end

endmodule

module sound_cmd_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned REP_DEPTH = 1
) (
    input  logic                             CLK,
    input  logic                             nSDZ80CLR,
    input  logic                             M68K_WR,
    input  logic                             M68K_RD,
    input  logic [DATA_W-1:0]                M68K_DIN,
    output logic [DATA_W-1:0]                M68K_DOUT,
    input  logic                             Z80_RD,
    input  logic                             Z80_WR,
    input  logic [DATA_W-1:0]                SDD_IN,
    output logic [DATA_W-1:0]                SDD_OUT,
    output logic                             nSDW,
`ifdef SOUND_CMD_OVF_EN
    output logic                             CMD_OVF,
    input  logic                             CMD_OVF_CLR,
`endif
    output logic [$clog2(CMD_DEPTH+1)-1:0]   CMD_COUNT,
    output logic                             CMD_FULL,
    output logic                             REP_VALID
);

    localparam int unsigned REP_CNT_W = $clog2(REP_DEPTH + 1);

    logic                 cmd_valid;
    logic                 cmd_drop;
    logic [DATA_W-1:0]    rep_head;
    logic [DATA_W-1:0]    last_rep_q;
    logic [REP_CNT_W-1:0] rep_count_unused;
    logic                 rep_full_unused;
    logic                 rep_drop_unused;

    sound_cmd_fifo_q #(
        .DATA_W (DATA_W),
        .DEPTH  (CMD_DEPTH)
    ) u_cmd_fifo (
        .CLK       (CLK),
        .nSDZ80CLR (nSDZ80CLR),
        .push      (M68K_WR),
        .pop       (Z80_RD),
        .din       (M68K_DIN),
        .head      (SDD_OUT),
        .count     (CMD_COUNT),
        .full      (CMD_FULL),
        .valid     (cmd_valid),
        .drop      (cmd_drop)
    );

    sound_cmd_fifo_q #(
        .DATA_W (DATA_W),
        .DEPTH  (REP_DEPTH)
    ) u_rep_fifo (
        .CLK       (CLK),
        .nSDZ80CLR (nSDZ80CLR),
        .push      (Z80_WR),
        .pop       (M68K_RD),
        .din       (SDD_IN),
        .head      (rep_head),
        .count     (rep_count_unused),
        .full      (rep_full_unused),
        .valid     (REP_VALID),
        .drop      (rep_drop_unused)
    );

    // NMI request is the inverted registered non-empty flag, so it cannot glitch on push+pop.
    assign nSDW = ~cmd_valid;

    // Sticky copy of the last reply popped, returned to the 68K when the reply queue is empty.
    always_ff @(posedge CLK or negedge nSDZ80CLR) begin
        if (!nSDZ80CLR) begin
            last_rep_q <= '0;
        end else if (M68K_RD && REP_VALID) begin
            last_rep_q <= rep_head;
        end
    end

    assign M68K_DOUT = REP_VALID ? rep_head : last_rep_q;

`ifdef SOUND_CMD_OVF_EN
    logic cmd_ovf_q;

    // A drop in the same cycle as a clear wins so the event is never lost.
    always_ff @(posedge CLK or negedge nSDZ80CLR) begin
        if (!nSDZ80CLR) begin
            cmd_ovf_q <= 1'b0;
        end else if (cmd_drop) begin
            cmd_ovf_q <= 1'b1;
        end else if (CMD_OVF_CLR) begin
            cmd_ovf_q <= 1'b0;
        end
    end

    assign CMD_OVF = cmd_ovf_q;
`else
    logic cmd_drop_unused;
    assign cmd_drop_unused = cmd_drop;
`endif

endmodule

// File: tb/tb_sound_cmd_fifo.sv
// Directed self-checking bench for sound_cmd_fifo: a default (4/1) instance and a legacy (1/1) instance.
`timescale 1ns/1ps

module tb_sound_cmd_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    int         n_cmp = 0;
    int         n_err = 0;

    // Default-depth instance
    logic       m_wr, m_rd, z_rd, z_wr;
    logic [7:0] m_din, sdd_in, m_dout, sdd_out;
    logic       nsdw, cmd_full, rep_valid;
    logic [2:0] cmd_count;
`ifdef SOUND_CMD_OVF_EN
    logic       ovf, ovf_clr;
`endif

    // Legacy single-entry instance
    logic       b_m_wr, b_m_rd, b_z_rd, b_z_wr;
    logic [7:0] b_m_din, b_sdd_in, b_m_dout, b_sdd_out;
    logic       b_nsdw, b_cmd_full, b_rep_valid;
    logic [0:0] b_cmd_count;
`ifdef SOUND_CMD_OVF_EN
    logic       b_ovf, b_ovf_clr;
`endif

    always #5 clk = ~clk;

    sound_cmd_fifo #(.DATA_W(8), .CMD_DEPTH(4), .REP_DEPTH(1)) u_dut (
        .CLK         (clk),
        .nSDZ80CLR   (rst_n),
        .M68K_WR     (m_wr),
        .M68K_RD     (m_rd),
        .M68K_DIN    (m_din),
        .M68K_DOUT   (m_dout),
        .Z80_RD      (z_rd),
        .Z80_WR      (z_wr),
        .SDD_IN      (sdd_in),
        .SDD_OUT     (sdd_out),
        .nSDW        (nsdw),
`ifdef SOUND_CMD_OVF_EN
        .CMD_OVF     (ovf),
        .CMD_OVF_CLR (ovf_clr),
`endif
        .CMD_COUNT   (cmd_count),
        .CMD_FULL    (cmd_full),
        .REP_VALID   (rep_valid)
    );

    sound_cmd_fifo #(.DATA_W(8), .CMD_DEPTH(1), .REP_DEPTH(1)) u_dut_legacy (
        .CLK         (clk),
        .nSDZ80CLR   (rst_n),
        .M68K_WR     (b_m_wr),
        .M68K_RD     (b_m_rd),
        .M68K_DIN    (b_m_din),
        .M68K_DOUT   (b_m_dout),
        .Z80_RD      (b_z_rd),
        .Z80_WR      (b_z_wr),
        .SDD_IN      (b_sdd_in),
        .SDD_OUT     (b_sdd_out),
        .nSDW        (b_nsdw),
`ifdef SOUND_CMD_OVF_EN
        .CMD_OVF     (b_ovf),
        .CMD_OVF_CLR (b_ovf_clr),
`endif
        .CMD_COUNT   (b_cmd_count),
        .CMD_FULL    (b_cmd_full),
        .REP_VALID   (b_rep_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_op(input logic wr, input logic rd, input logic [7:0] d);
        m_wr = wr; z_rd = rd; m_din = d;
        tick();
        m_wr = 1'b0; z_rd = 1'b0;
    endtask

    task automatic rep_op(input logic wr, input logic rd, input logic [7:0] d);
        z_wr = wr; m_rd = rd; sdd_in = d;
        tick();
        z_wr = 1'b0; m_rd = 1'b0;
    endtask

    task automatic leg_op(input logic wr, input logic rd, input logic [7:0] d);
        b_m_wr = wr; b_z_rd = rd; b_m_din = d;
        tick();
        b_m_wr = 1'b0; b_z_rd = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [4];

        m_wr = 0; m_rd = 0; z_rd = 0; z_wr = 0; m_din = 0; sdd_in = 0;
        b_m_wr = 0; b_m_rd = 0; b_z_rd = 0; b_z_wr = 0; b_m_din = 0; b_sdd_in = 0;
`ifdef SOUND_CMD_OVF_EN
        ovf_clr = 0; b_ovf_clr = 0;
`endif
        rst_n = 1'b0;
        #12;
        check("rst_count", 32'(cmd_count), 32'd0);
        check("rst_nsdw", 32'(nsdw), 32'd1);
        check("rst_full", 32'(cmd_full), 32'd0);
        check("rst_sdd_out", 32'(sdd_out), 32'h00);
        check("rst_rep_valid", 32'(rep_valid), 32'd0);
        check("rst_m68k_dout", 32'(m_dout), 32'h00);
        tick();
        rst_n = 1'b1;

        // Reset while commands are queued
        cmd_op(1, 0, 8'h11);
        cmd_op(1, 0, 8'h22);
        check("pre_rst_count", 32'(cmd_count), 32'd2);
        check("pre_rst_head", 32'(sdd_out), 32'h11);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(cmd_count), 32'd0);
        check("mid_rst_nsdw", 32'(nsdw), 32'd1);
        check("mid_rst_sdd_out", 32'(sdd_out), 32'h00);
        tick();
        rst_n = 1'b1;

        // Ordering and full
        cmd_op(1, 0, 8'h01);
        check("nsdw_latency", 32'(nsdw), 32'd0);
        cmd_op(1, 0, 8'h02);
        cmd_op(1, 0, 8'h03);
        check("full_at_3", 32'(cmd_full), 32'd0);
        cmd_op(1, 0, 8'h04);
        check("full_at_4", 32'(cmd_full), 32'd1);
        check("count_at_4", 32'(cmd_count), 32'd4);

        // Overflow drop
        cmd_op(1, 0, 8'h55);
        check("ovf_count", 32'(cmd_count), 32'd4);
        check("ovf_head", 32'(sdd_out), 32'h01);
`ifdef SOUND_CMD_OVF_EN
        check("ovf_flag_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_flag_clr", 32'(ovf), 32'd0);
        ovf_clr = 1'b1; cmd_op(1, 0, 8'h66); ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(ovf), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
`endif
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("order_%0d", i), 32'(sdd_out), 32'(i));
            cmd_op(0, 1, 8'h00);
        end
        check("drain_nsdw", 32'(nsdw), 32'd1);
        check("drain_full", 32'(cmd_full), 32'd0);
        check("drain_sdd_out", 32'(sdd_out), 32'h00);
        cmd_op(0, 1, 8'h00);
        check("empty_pop_count", 32'(cmd_count), 32'd0);

        // Simultaneous push+pop while empty: no bypass
        cmd_op(1, 1, 8'hA5);
        check("sim_empty_count", 32'(cmd_count), 32'd1);
        check("sim_empty_head", 32'(sdd_out), 32'hA5);
        cmd_op(0, 1, 8'h00);

        // Simultaneous push+pop while full, with pointer wrap
        cmd_op(1, 0, 8'hB1);
        cmd_op(1, 0, 8'hB2);
        cmd_op(1, 0, 8'hB3);
        cmd_op(1, 0, 8'hB4);
        cmd_op(1, 1, 8'hC5);
        check("sim_full_count", 32'(cmd_count), 32'd4);
        check("sim_full_full", 32'(cmd_full), 32'd1);
        check("sim_full_nsdw", 32'(nsdw), 32'd0);
        exp_q[0] = 8'hB2; exp_q[1] = 8'hB3; exp_q[2] = 8'hB4; exp_q[3] = 8'hC5;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_%0d", i), 32'(sdd_out), 32'(exp_q[i]));
            cmd_op(0, 1, 8'h00);
        end
        check("wrap_nsdw", 32'(nsdw), 32'd1);

        // Reply path and sticky read-back
        rep_op(1, 0, 8'h7E);
        check("rep_valid", 32'(rep_valid), 32'd1);
        check("rep_head", 32'(m_dout), 32'h7E);
        rep_op(1, 0, 8'h7F);
        check("rep_full_drop", 32'(m_dout), 32'h7E);
        rep_op(0, 1, 8'h00);
        check("rep_pop_valid", 32'(rep_valid), 32'd0);
        check("rep_sticky_1", 32'(m_dout), 32'h7E);
        rep_op(0, 1, 8'h00);
        check("rep_sticky_2", 32'(m_dout), 32'h7E);
        rep_op(1, 1, 8'h33);
        check("rep_sim_empty_valid", 32'(rep_valid), 32'd1);
        check("rep_sim_empty_head", 32'(m_dout), 32'h33);
        rep_op(1, 1, 8'h44);
        check("rep_sim_full_head", 32'(m_dout), 32'h44);
        rep_op(0, 1, 8'h00);
        check("rep_final_valid", 32'(rep_valid), 32'd0);
        check("rep_final_sticky", 32'(m_dout), 32'h44);

        // Legacy single-entry latch
        check("leg_idle_nsdw", 32'(b_nsdw), 32'd1);
        leg_op(1, 0, 8'h10);
        check("leg_nsdw_low", 32'(b_nsdw), 32'd0);
        check("leg_count", 32'(b_cmd_count), 32'd1);
        check("leg_full", 32'(b_cmd_full), 32'd1);
        check("leg_head", 32'(b_sdd_out), 32'h10);
        leg_op(1, 0, 8'h20);
        check("leg_drop", 32'(b_sdd_out), 32'h10);
        leg_op(1, 1, 8'h30);
        check("leg_sim_full_head", 32'(b_sdd_out), 32'h30);
        check("leg_sim_full_nsdw", 32'(b_nsdw), 32'd0);
        leg_op(0, 1, 8'h00);
        check("leg_nsdw_high", 32'(b_nsdw), 32'd1);
        check("leg_empty_head", 32'(b_sdd_out), 32'h00);
        leg_op(1, 1, 8'hA5);
        check("leg_sim_empty_count", 32'(b_cmd_count), 32'd1);
        check("leg_sim_empty_head", 32'(b_sdd_out), 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
